video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Raster timing generator directly upstream of the gfx compositor.
- Produces the pixel coordinate pair (o_x, o_y) and the o_v_sync that gfx and its sprites consume.
- Also produces o_h_sync, data-enable and per-frame/per-line strobes for the downstream video encoder.
- Fully parameterised; defaults are 640x480@60 (25.175 MHz pixel rate).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of o_h_sync (0 = active-low)
- V_SYNC_POL, 0, asserted level of o_v_sync (0 = active-low)

Ports:
- i_clk  in  1  system clock; all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  pixel-clock enable; counters advance only when high
- o_x  out  16  horizontal counter, 0..H_TOTAL-1; feeds gfx i_x
- o_y  out  16  vertical counter, 0..V_TOTAL-1; feeds gfx i_y
- o_h_sync  out  1  horizontal sync at H_SYNC_POL level while asserted
- o_v_sync  out  1  vertical sync at V_SYNC_POL level while asserted; feeds gfx i_v_sync
- o_de  out  1  high when o_x < H_ACTIVE and o_y < V_ACTIVE
- o_line_start  out  1  high while o_x == 0
- o_frame_start  out  1  high while o_x == 0 and o_y == 0

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both must be ≤ 65536; counters are 16-bit unsigned.
- Reset (asserted, asynchronous):
  - o_x=0, o_y=0.
  - o_de=1, o_line_start=1, o_frame_start=1.
  - o_h_sync=!H_SYNC_POL, o_v_sync=!V_SYNC_POL.
  - After deassertion the first enabled cycle moves to (1,0).
- Counting, on a rising edge with i_en=1:
  - If o_x < H_TOTAL-1: o_x += 1.
  - Else: o_x = 0, and o_y = (o_y == V_TOTAL-1) ? 0 : o_y+1.
  - With i_en=0, all outputs hold.
- Output registration:
  - All outputs are registers, decoded from the next counter values.
  - Every output is therefore exactly consistent with the o_x/o_y presented in the same cycle.
  - Zero latency between coordinates and flags.
  - No combinational path from i_en to any output.
- Sync decode:
  - o_h_sync asserted iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - o_v_sync asserted iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (default 490..491).
  - o_v_sync is decoded from the line counter only. It changes at x=0 of the line, not mid-line.
- Strobes: o_line_start and o_frame_start are level-true for the whole enabled-pixel period. Consumers qualify them with i_en.
- Wrap, (H_TOTAL-1, V_TOTAL-1) -> (0,0): in the same update o_frame_start=1, o_line_start=1, o_de=1, and o_v_sync is inactive.
- Reset mid-frame: immediate asynchronous return to the reset state regardless of i_en. No partial line is completed.
- i_en held low through a reset release: outputs stay at reset values until the first enabled edge.

Test Plan:
- Reset and first step: hold i_rst_n=0 with i_en=1 → (0,0), de=1, h_sync=1, v_sync=1, frame_start=1. Release, one enabled edge → (1,0), frame_start=0, line_start=0.
- Line wrap: run to x=799, y=5, then one enabled edge → x=0, y=6, line_start=1. o_de=0 for x=640..799 and 1 again at x=0.
- H sync: scan line 0 → h_sync=0 exactly for x=656..751 (96 cycles), 1 elsewhere. Repeat with H_SYNC_POL=1 → inverted.
- V sync and frame wrap: run a full frame (420000 enabled cycles) → v_sync=0 exactly for y=490..491 (1600 pixels). Then (799,524) → (0,0) with frame_start=1, and the count returns to the start every 420000 cycles.
- Enable gating: toggle i_en at random with ~30% duty over 2 frames → counters advance only on enabled edges. The sequence matches the reference model, and outputs hold while i_en=0.
- Async reset mid-frame: assert i_rst_n=0 between clock edges at (300,200) → outputs go to reset values before the next edge. Release resumes from (0,0). Small-parameter build (H 4/1/1/1, V 3/1/1/1) → period 7x6=42 enabled cycles.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Raster timing bus between the timing generator and its consumers.
//
// Signals:
//   i_en           pixel-clock enable, supplied to the generator
//   o_x, o_y       current raster coordinate (16-bit unsigned)
//   o_h_sync       horizontal sync at the configured polarity
//   o_v_sync       vertical sync at the configured polarity
//   o_de           data enable, high inside the visible window
//   o_line_start   high while o_x == 0
//   o_frame_start  high while o_x == 0 and o_y == 0
//
// master: the timing generator (drives coordinates and flags)
// slave : a consumer (drives the enable, observes the timing)
interface video_timing_gen_if;
    logic        i_en;
    logic [15:0] o_x;
    logic [15:0] o_y;
    logic        o_h_sync;
    logic        o_v_sync;
    logic        o_de;
    logic        o_line_start;
    logic        o_frame_start;

    modport master (
        input  i_en,
        output o_x, o_y, o_h_sync, o_v_sync, o_de, o_line_start, o_frame_start
    );

    modport slave (
        output i_en,
        input  o_x, o_y, o_h_sync, o_v_sync, o_de, o_line_start, o_frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator feeding the gfx compositor and the video encoder.
//
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      video_timing_gen_if.master: i_en in; o_x, o_y, o_h_sync,
//            o_v_sync, o_de, o_line_start, o_frame_start out
//
// Every output is a register loaded from the decode of the *next* counter
// values, so flags always line up with the coordinate shown in the same
// cycle and no output has a combinational path from i_en.
// H_TOTAL and V_TOTAL must each be at most 65536.
module video_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    video_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 17-bit thresholds so a total of exactly 65536 still compares correctly
    localparam logic [16:0] H_LAST     = 17'(H_TOTAL - 1);
    localparam logic [16:0] V_LAST     = 17'(V_TOTAL - 1);
    localparam logic [16:0] H_ACT_END  = 17'(H_ACTIVE);
    localparam logic [16:0] V_ACT_END  = 17'(V_ACTIVE);
    localparam logic [16:0] HS_START   = 17'(H_ACTIVE + H_FP);
    localparam logic [16:0] HS_END     = 17'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [16:0] VS_START   = 17'(V_ACTIVE + V_FP);
    localparam logic [16:0] VS_END     = 17'(V_ACTIVE + V_FP + V_SYNC);

    // Half-open window test on a 16-bit counter value
    function automatic logic in_window(input logic [15:0] v,
                                       input logic [16:0] lo,
                                       input logic [16:0] hi);
        return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
    endfunction

    logic [15:0] x_r;
    logic [15:0] y_r;
    logic        h_sync_r;
    logic        v_sync_r;
    logic        de_r;
    logic        line_start_r;
    logic        frame_start_r;

    logic [15:0] x_nxt_s;
    logic [15:0] y_nxt_s;

    // Next raster position: step x, wrap into the next line, wrap the frame
    always_comb begin
        x_nxt_s = 16'd0;
        y_nxt_s = y_r;
        if ({1'b0, x_r} < H_LAST) begin
            x_nxt_s = x_r + 16'd1;
        end else begin
            x_nxt_s = 16'd0;
            if ({1'b0, y_r} == V_LAST) begin
                y_nxt_s = 16'd0;
            end else begin
                y_nxt_s = y_r + 16'd1;
            end
        end
    end

    // Counters and flags, all decoded from the next position on enabled edges
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_r           <= 16'd0;
            y_r           <= 16'd0;
            h_sync_r      <= ~H_SYNC_POL;
            v_sync_r      <= ~V_SYNC_POL;
            de_r          <= 1'b1;
            line_start_r  <= 1'b1;
            frame_start_r <= 1'b1;
        end else if (bus.i_en) begin
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            h_sync_r      <= in_window(x_nxt_s, HS_START, HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
            // Depends on y only, so it can only change where x wraps to 0
            v_sync_r      <= in_window(y_nxt_s, VS_START, VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
            de_r          <= ({1'b0, x_nxt_s} < H_ACT_END) && ({1'b0, y_nxt_s} < V_ACT_END);
            line_start_r  <= (x_nxt_s == 16'd0);
            frame_start_r <= (x_nxt_s == 16'd0) && (y_nxt_s == 16'd0);
        end else begin
            x_r           <= x_r;
            y_r           <= y_r;
            h_sync_r      <= h_sync_r;
            v_sync_r      <= v_sync_r;
            de_r          <= de_r;
            line_start_r  <= line_start_r;
            frame_start_r <= frame_start_r;
        end
    end

    assign bus.o_x           = x_r;
    assign bus.o_y           = y_r;
    assign bus.o_h_sync      = h_sync_r;
    assign bus.o_v_sync      = v_sync_r;
    assign bus.o_de          = de_r;
    assign bus.o_line_start  = line_start_r;
    assign bus.o_frame_start = frame_start_r;

endmodule
